// File: rtl/align_ctrl_pkg.sv
// align_ctrl_pkg: shared widths and FSM encoding for the exponent-alignment sequencer
package align_ctrl_pkg;
    localparam int EXP_W = 8;
    localparam int MAN_W = 24;
    localparam int CNT_W = $clog2(MAN_W + 1);
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2, DONE = 2'd3} state_e;
endpackage

// File: rtl/align_ctrl_if.sv
// align_ctrl_if: handshake and strobe bundle between the FP adder control and the aligner
// slave (aligner side): in start, exp_a, exp_b, lsb_a, lsb_b; out load/shift strobes, exp_out, a_smaller, sticky, busy, done
interface align_ctrl_if;
    import align_ctrl_pkg::*;
    logic             start;
    logic [EXP_W-1:0] exp_a;
    logic [EXP_W-1:0] exp_b;
    logic             lsb_a;
    logic             lsb_b;
    logic             ld_mantice_a;
    logic             ld_mantice_b;
    logic             shift_right_a;
    logic             shift_right_b;
    logic [EXP_W-1:0] exp_out;
    logic             a_smaller;
    logic             sticky;
    logic             busy;
    logic             done;
    modport slave (
        input  start, exp_a, exp_b, lsb_a, lsb_b,
        output ld_mantice_a, ld_mantice_b, shift_right_a, shift_right_b, exp_out, a_smaller, sticky, busy, done
    );
    modport master (
        output start, exp_a, exp_b, lsb_a, lsb_b,
        input  ld_mantice_a, ld_mantice_b, shift_right_a, shift_right_b, exp_out, a_smaller, sticky, busy, done
    );
endinterface

// File: rtl/align_ctrl_shift_counter.sv
// align_ctrl_shift_counter: loadable down-counter of remaining shifts
// ports: clk, rst, ld_i (load din_i), dec_i (count down), din_i, zero_next_o (count == 1, last shift)
module align_ctrl_shift_counter
    import align_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_i,
    input  logic             dec_i,
    input  logic [CNT_W-1:0] din_i,
    output logic             zero_next_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = ld_i ? din_i : dec_i ? cnt_q - 1'b1 : cnt_q;
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
    assign zero_next_o = cnt_q == CNT_W'(1);
endmodule

// File: rtl/align_ctrl.sv
// align_ctrl: exponent-alignment sequencer driving the two mantissa shift registers of the FP adder
// ports: clk, rst (sync, active-high), bus (align_ctrl_if.slave: start/exponents/lsbs in, strobes and result out)
module align_ctrl
    import align_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    align_ctrl_if.slave  bus
);
    state_e           state_q, state_d;
    logic [EXP_W-1:0] exp_a_q, exp_a_d, exp_b_q, exp_b_d, exp_out_q, exp_out_d;
    logic             a_smaller_q, a_smaller_d, sticky_q, sticky_d;
    logic             a_lt, zero_next;
    logic [EXP_W:0]   diff;
    logic [CNT_W-1:0] n;
    assign a_lt = exp_a_q < exp_b_q;
    // one extra bit so 255 vs 0 cannot wrap
    assign diff = a_lt ? {1'b0, exp_b_q} - {1'b0, exp_a_q} : {1'b0, exp_a_q} - {1'b0, exp_b_q};
    assign n    = diff >= (EXP_W+1)'(MAN_W) ? CNT_W'(MAN_W) : diff[CNT_W-1:0];
    always_comb begin
        state_d     = state_q;
        exp_a_d     = exp_a_q;
        exp_b_d     = exp_b_q;
        exp_out_d   = exp_out_q;
        a_smaller_d = a_smaller_q;
        sticky_d    = sticky_q;
        case (state_q)
            IDLE: if (bus.start) begin
                exp_a_d = bus.exp_a;
                exp_b_d = bus.exp_b;
                state_d = LOAD;
            end
            LOAD: begin
                exp_out_d   = a_lt ? exp_b_q : exp_a_q;
                a_smaller_d = a_lt;
                sticky_d    = 1'b0;
                state_d     = n != '0 ? SHIFT : DONE;
            end
            SHIFT: begin
                // the lsb presented now is the bit leaving the register on this edge
                sticky_d = sticky_q | (a_smaller_q ? bus.lsb_a : bus.lsb_b);
                state_d  = zero_next ? DONE : SHIFT;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            exp_a_q     <= '0;
            exp_b_q     <= '0;
            exp_out_q   <= '0;
            a_smaller_q <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            exp_a_q     <= exp_a_d;
            exp_b_q     <= exp_b_d;
            exp_out_q   <= exp_out_d;
            a_smaller_q <= a_smaller_d;
            sticky_q    <= sticky_d;
        end
    end
    align_ctrl_shift_counter u_cnt (
        .clk         (clk),
        .rst         (rst),
        .ld_i        (state_q == LOAD),
        .dec_i       (state_q == SHIFT),
        .din_i       (n),
        .zero_next_o (zero_next)
    );
    assign bus.ld_mantice_a  = state_q == LOAD;
    assign bus.ld_mantice_b  = state_q == LOAD;
    assign bus.shift_right_a = state_q == SHIFT && a_smaller_q;
    assign bus.shift_right_b = state_q == SHIFT && !a_smaller_q;
    assign bus.exp_out       = exp_out_q;
    assign bus.a_smaller     = a_smaller_q;
    assign bus.sticky        = sticky_q;
    assign bus.busy          = state_q != IDLE;
    assign bus.done          = state_q == DONE;
endmodule

// File: tb/tb_align_ctrl.sv
// tb_align_ctrl: directed self-checking bench for align_ctrl
module tb_align_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int pass_cnt = 0;
    int total = 0;
    logic [31:0] lda_m, ldb_m, sa_m, sb_m, dn_m, bz_m;
    align_ctrl_if bus ();
    align_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    // cycle k = k-th cycle after the start cycle; outputs sampled at the negedge of each cycle
    task automatic run(input logic [7:0] ea, input logic [7:0] eb, input logic [31:0] pa, input logic [31:0] pb, input logic [31:0] restart);
        lda_m = '0; ldb_m = '0; sa_m = '0; sb_m = '0; dn_m = '0; bz_m = '0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            lda_m[k] = bus.ld_mantice_a;
            ldb_m[k] = bus.ld_mantice_b;
            sa_m[k]  = bus.shift_right_a;
            sb_m[k]  = bus.shift_right_b;
            dn_m[k]  = bus.done;
            bz_m[k]  = bus.busy;
            bus.start = (k == 0) || restart[k];
            bus.exp_a = (k == 0) ? ea : ~ea;
            bus.exp_b = (k == 0) ? eb : ~eb;
            bus.lsb_a = (k >= 2) ? pa[k-2] : 1'b0;
            bus.lsb_b = (k >= 2) ? pb[k-2] : 1'b0;
        end
    endtask

    task automatic test_reset();
        bus.start = 0; bus.exp_a = 0; bus.exp_b = 0; bus.lsb_a = 0; bus.lsb_b = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", bus.busy); else pass_cnt++;
        total++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b exp 0", bus.done); else pass_cnt++;
        total++; if ({bus.ld_mantice_a, bus.ld_mantice_b, bus.shift_right_a, bus.shift_right_b} !== 4'b0) $display("FAIL reset_strobes got %b exp 0000", {bus.ld_mantice_a, bus.ld_mantice_b, bus.shift_right_a, bus.shift_right_b}); else pass_cnt++;
        total++; if ({bus.exp_out, bus.a_smaller, bus.sticky} !== 10'b0) $display("FAIL reset_result got %h exp 0", {bus.exp_out, bus.a_smaller, bus.sticky}); else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        run(8'd130, 8'd127, 32'h0, 32'h0, 32'h0);
        total++; if (lda_m !== 32'h2) $display("FAIL basic_lda got %h exp %h", lda_m, 32'h2); else pass_cnt++;
        total++; if (ldb_m !== 32'h2) $display("FAIL basic_ldb got %h exp %h", ldb_m, 32'h2); else pass_cnt++;
        total++; if (sb_m !== 32'h1C) $display("FAIL basic_shift_b got %h exp %h", sb_m, 32'h1C); else pass_cnt++;
        total++; if (sa_m !== 32'h0) $display("FAIL basic_shift_a got %h exp 0", sa_m); else pass_cnt++;
        total++; if (dn_m !== 32'h20) $display("FAIL basic_done got %h exp %h", dn_m, 32'h20); else pass_cnt++;
        total++; if (bz_m !== 32'h3E) $display("FAIL basic_busy got %h exp %h", bz_m, 32'h3E); else pass_cnt++;
        total++; if (bus.exp_out !== 8'd130) $display("FAIL basic_exp got %0d exp 130", bus.exp_out); else pass_cnt++;
        total++; if (bus.a_smaller !== 1'b0) $display("FAIL basic_a_smaller got %b exp 0", bus.a_smaller); else pass_cnt++;
    endtask

    task automatic test_equal();
        run(8'd100, 8'd100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
        total++; if (lda_m !== 32'h2) $display("FAIL equal_ld got %h exp %h", lda_m, 32'h2); else pass_cnt++;
        total++; if ((sa_m | sb_m) !== 32'h0) $display("FAIL equal_shift got %h exp 0", sa_m | sb_m); else pass_cnt++;
        total++; if (dn_m !== 32'h4) $display("FAIL equal_done got %h exp %h", dn_m, 32'h4); else pass_cnt++;
        total++; if (bus.exp_out !== 8'd100) $display("FAIL equal_exp got %0d exp 100", bus.exp_out); else pass_cnt++;
        total++; if ({bus.a_smaller, bus.sticky} !== 2'b00) $display("FAIL equal_flags got %b exp 00", {bus.a_smaller, bus.sticky}); else pass_cnt++;
    endtask

    task automatic test_cap();
        run(8'd10, 8'd200, 32'h0, 32'hFFFF_FFFF, 32'h0);
        total++; if (sa_m !== 32'h03FF_FFFC) $display("FAIL cap_shift_a got %h exp %h", sa_m, 32'h03FF_FFFC); else pass_cnt++;
        total++; if (sb_m !== 32'h0) $display("FAIL cap_shift_b got %h exp 0", sb_m); else pass_cnt++;
        total++; if (dn_m !== 32'h0400_0000) $display("FAIL cap_done got %h exp %h", dn_m, 32'h0400_0000); else pass_cnt++;
        total++; if (bus.exp_out !== 8'd200) $display("FAIL cap_exp got %0d exp 200", bus.exp_out); else pass_cnt++;
        total++; if ({bus.a_smaller, bus.sticky} !== 2'b10) $display("FAIL cap_flags got %b exp 10", {bus.a_smaller, bus.sticky}); else pass_cnt++;
        run(8'd255, 8'd0, 32'hFFFF_FFFF, 32'h0080_0000, 32'h0);
        total++; if (sb_m !== 32'h03FF_FFFC) $display("FAIL wide_shift_b got %h exp %h", sb_m, 32'h03FF_FFFC); else pass_cnt++;
        total++; if (dn_m !== 32'h0400_0000) $display("FAIL wide_done got %h exp %h", dn_m, 32'h0400_0000); else pass_cnt++;
        total++; if (bus.exp_out !== 8'd255) $display("FAIL wide_exp got %0d exp 255", bus.exp_out); else pass_cnt++;
        total++; if ({bus.a_smaller, bus.sticky} !== 2'b01) $display("FAIL wide_flags got %b exp 01", {bus.a_smaller, bus.sticky}); else pass_cnt++;
    endtask

    task automatic test_sticky();
        run(8'd20, 8'd16, 32'hFFFF_FFFF, 32'h4, 32'h0);
        total++; if (sb_m !== 32'h3C) $display("FAIL sticky_shift got %h exp %h", sb_m, 32'h3C); else pass_cnt++;
        total++; if (bus.sticky !== 1'b1) $display("FAIL sticky_set got %b exp 1", bus.sticky); else pass_cnt++;
        run(8'd20, 8'd16, 32'hFFFF_FFFF, 32'h0, 32'h0);
        total++; if (bus.sticky !== 1'b0) $display("FAIL sticky_clear got %b exp 0", bus.sticky); else pass_cnt++;
        run(8'd16, 8'd20, 32'h1, 32'hFFFF_FFFF, 32'h0);
        total++; if (sa_m !== 32'h3C) $display("FAIL sticky_a_shift got %h exp %h", sa_m, 32'h3C); else pass_cnt++;
        total++; if ({bus.a_smaller, bus.sticky} !== 2'b11) $display("FAIL sticky_a_flags got %b exp 11", {bus.a_smaller, bus.sticky}); else pass_cnt++;
    endtask

    task automatic test_abort();
        logic [31:0] seen;
        seen = '0;
        @(negedge clk);
        bus.start = 1'b1; bus.exp_a = 8'd20; bus.exp_b = 8'd16;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (bus.shift_right_b !== 1'b1) $display("FAIL abort_in_shift got %b exp 1", bus.shift_right_b); else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if ({bus.busy, bus.done, bus.ld_mantice_a, bus.ld_mantice_b, bus.shift_right_a, bus.shift_right_b} !== 6'b0) $display("FAIL abort_ctrl got %b exp 000000", {bus.busy, bus.done, bus.ld_mantice_a, bus.ld_mantice_b, bus.shift_right_a, bus.shift_right_b}); else pass_cnt++;
        total++; if ({bus.exp_out, bus.a_smaller, bus.sticky} !== 10'b0) $display("FAIL abort_result got %h exp 0", {bus.exp_out, bus.a_smaller, bus.sticky}); else pass_cnt++;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            seen[k] = bus.done | bus.busy;
        end
        total++; if (seen !== 32'h0) $display("FAIL abort_no_done got %h exp 0", seen); else pass_cnt++;
        run(8'd20, 8'd16, 32'h0, 32'h0, 32'h0);
        total++; if (dn_m !== 32'h40) $display("FAIL abort_rerun_done got %h exp %h", dn_m, 32'h40); else pass_cnt++;
        total++; if (bus.exp_out !== 8'd20) $display("FAIL abort_rerun_exp got %0d exp 20", bus.exp_out); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        run(8'd130, 8'd127, 32'h0, 32'h0, 32'h28);
        total++; if (lda_m !== 32'h2) $display("FAIL b2b_ld got %h exp %h", lda_m, 32'h2); else pass_cnt++;
        total++; if (sb_m !== 32'h1C) $display("FAIL b2b_shift got %h exp %h", sb_m, 32'h1C); else pass_cnt++;
        total++; if (dn_m !== 32'h20) $display("FAIL b2b_done got %h exp %h", dn_m, 32'h20); else pass_cnt++;
        total++; if (bz_m !== 32'h3E) $display("FAIL b2b_busy got %h exp %h", bz_m, 32'h3E); else pass_cnt++;
        total++; if (bus.exp_out !== 8'd130) $display("FAIL b2b_exp got %0d exp 130", bus.exp_out); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_equal();
        test_cap();
        test_sticky();
        test_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
